mem_access_ctrl: RTL



---
 rtl/mem_access_ctrl_if.sv | 28 ++
 rtl/mem_access_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bus between the MEM-stage pipeline, mem_access_ctrl and the data RAM port.
// slave: the controller side; master: the pipeline/RAM side that drives requests and read data.
interface mem_access_ctrl_if #(parameter int ADDR_BITS = 12);
  logic                 req;
  logic                 we;
  logic [2:0]           op;
  logic [ADDR_BITS-1:0] addr;
  logic [31:0]          wdata;
  logic                 busy;
  logic                 done;
  logic [31:0]          rdata;
  logic                 err;
  logic                 ram_rw;
  logic [3:0]           ram_sel;
  logic [ADDR_BITS-3:0] ram_addr;
  logic [31:0]          ram_data_in;
  logic [31:0]          ram_data_out;

  modport slave (
    input  req, we, op, addr, wdata, ram_data_out,
    output busy, done, rdata, err, ram_rw, ram_sel, ram_addr, ram_data_in
  );

  modport master (
    output req, we, op, addr, wdata, ram_data_out,
    input  busy, done, rdata, err, ram_rw, ram_sel, ram_addr, ram_data_in
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store initiator for the data RAM: IDLE -> ACCESS -> DONE, one access per 3 cycles.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word requests skip the RAM and finish with err=1.
module mem_access_ctrl #(
  parameter int ADDR_BITS = 12
) (
  input logic         clk,
  input logic         rst,
  mem_access_ctrl_if.slave bus
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 we_p0;
  logic [2:0]           op_p0;
  logic [ADDR_BITS-1:0] addr_p0;
  logic [DATA_W-1:0]    wdata_p0;
  logic [DATA_W-1:0]    rdata_p1;
  logic                 ram_rw;
  logic [3:0]           ram_sel;
  logic [ADDR_BITS-3:0] ram_addr;
  logic [DATA_W-1:0]    ram_data_in;

  // op[1:0]: 00 byte, 01 half, 1x word (undefined encodings fall into word)
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [2:0] op,
                                                    input logic [1:0] off);
    logic [7:0]               b;
    logic [15:0]              h;
    logic signed [DATA_W-1:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (op[1:0])
      2'b00:   r = op[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = op[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [2:0] op, input logic [1:0] off);
    case (op[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_data(input logic [2:0] op, input logic [1:0] off,
                                                  input logic [DATA_W-1:0] w);
    case (op[1:0])
      2'b00:   return {24'b0, w[7:0]} << {off, 3'b000};
      2'b01:   return off[1] ? {w[15:0], 16'b0} : {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  logic err_p1;

  assign misaligned = ((bus.op[1:0] == 2'b01) && bus.addr[0]) ||
                      (bus.op[1] && (bus.addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (rst)
      err_p1 <= 1'b0;
    else if (state == IDLE && bus.req)
      err_p1 <= misaligned;
  end

  assign bus.err = err_p1 && (state == DONE);
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Stage p0: request captured in IDLE
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req) begin
      we_p0    <= bus.we;
      op_p0    <= bus.op;
      addr_p0  <= bus.addr;
      wdata_p0 <= bus.wdata;
    end
  end

  // Stage p1: load result registered at the ACCESS edge
  always_ff @(posedge clk) begin
    if (rst)
      rdata_p1 <= '0;
    else if (state == ACCESS && !we_p0)
      rdata_p1 <= load_extend(bus.ram_data_out, op_p0, addr_p0[1:0]);
  end

  always_comb begin
    state_nxt   = state;
    ram_rw      = 1'b0;
    ram_sel     = 4'b0000;
    ram_addr    = '0;
    ram_data_in = '0;
    case (state)
      IDLE: begin
        if (bus.req) begin
`ifdef MEM_MISALIGN_TRAP_EN
          state_nxt = misaligned ? DONE : ACCESS;
`else
          state_nxt = ACCESS;
`endif
        end
      end
      ACCESS: begin
        state_nxt = DONE;
        ram_addr  = addr_p0[ADDR_BITS-1:2];
        if (we_p0) begin
          ram_rw      = 1'b1;
          ram_sel     = lane_sel(op_p0, addr_p0[1:0]);
          ram_data_in = lane_data(op_p0, addr_p0[1:0], wdata_p0);
        end else begin
          ram_sel = 4'b1111;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.rdata       = rdata_p1;
  assign bus.ram_rw      = ram_rw;
  assign bus.ram_sel     = ram_sel;
  assign bus.ram_addr    = ram_addr;
  assign bus.ram_data_in = ram_data_in;
endmodule
